// File: rtl/ex_muldiv_unit_pkg.sv
// Funct codes and multiply/divide sequencer states shared across the EX stage.
package mips_funct_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    SIGN = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mfResult;

  modport master (
    output start, operation, a, b, flush,
    input  busy, hi, lo, mfResult
  );

  modport slave (
    input  start, operation, a, b, flush,
    output busy, hi, lo, mfResult
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle over a shared
// 64-bit shift register, signs applied in a final correction cycle.
module ex_muldiv_unit
  import mips_funct_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);

  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  muldiv_state_t      state;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_save;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;
  logic               div0;

  logic               is_mul_op;
  logic               is_div_op;
  logic               signed_op;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_try;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // Command decode, one iteration step for each datapath, and sign correction.
  always_comb begin
    is_mul_op = (bus.operation == F_MULT) || (bus.operation == F_MULTU);
    is_div_op = (bus.operation == F_DIV)  || (bus.operation == F_DIVU);
    signed_op = (bus.operation == F_MULT) || (bus.operation == F_DIV);

    // Multiply: conditional add into the upper half, then shift right with carry.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {add_sum, acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the partial remainder, subtract if it fits.
    rem_try  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge   = (rem_try >= {1'b0, opnd});
    rem_sub  = rem_try - {1'b0, opnd};
    div_next = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_try[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};

    prod = neg_q ? ('0 - acc) : acc;
    quo  = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem  = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer: accept in IDLE, iterate WIDTH times, correct signs and write HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_save <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (is_mul_op || is_div_op) begin
              state  <= is_div_op ? DIV : MUL;
              busy_r <= 1'b1;
              cnt    <= '0;
              acc    <= {{WIDTH{1'b0}}, mag(bus.a, signed_op)};
              opnd   <= mag(bus.b, signed_op);
              a_save <= bus.a;
              neg_q  <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r  <= signed_op && bus.a[WIDTH-1];
              is_div <= is_div_op;
              div0   <= (bus.b == '0);
            end else if (bus.operation == F_MTHI) begin
              hi_r <= bus.a;
            end else if (bus.operation == F_MTLO) begin
              lo_r <= bus.a;
            end
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            acc <= (state == DIV) ? div_next : mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == LAST_ITER) state <= SIGN;
          end
        end
        SIGN: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          if (!bus.flush) begin
            if (!is_div) begin
              {hi_r, lo_r} <= prod;
            end else if (div0) begin
              lo_r <= '1;
              hi_r <= a_save;
            end else begin
              lo_r <= quo;
              hi_r <= rem;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.mfResult = (bus.operation == F_MFHI) ? hi_r :
                        (bus.operation == F_MFLO) ? lo_r : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboarded random/directed bench for the multiply/divide unit.
module tb_ex_muldiv_unit;
  import mips_funct_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic reset;
  ex_muldiv_unit_if #(.WIDTH(32)) bus();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the architectural rules.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint sa, sb2, p;
    logic [63:0] up;
    sa  = $signed(a);
    sb2 = $signed(b);
    h = mhi;
    l = mlo;
    case (op)
      F_MULT:  begin p = sa * sb2; {h, l} = p; end
      F_MULTU: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      F_DIV:   if (b == 0) begin l = '1; h = a; end
               else begin l = 32'(sa / sb2); h = 32'(sa % sb2); end
      F_DIVU:  if (b == 0) begin l = '1; h = a; end
               else begin l = a / b; h = a % b; end
      F_MTHI:  h = a;
      F_MTLO:  l = a;
      default: ;
    endcase
  endtask

  // Monitor: each falling edge of busy is a completion checked against the scoreboard.
  initial begin
    bit   prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 0;
        bcnt = 0;
      end else begin
        if (bus.busy) bcnt++;
        else if (prev_busy) begin
          if (sb.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("done_hi", bus.hi, e.hi);
            chk("done_lo", bus.lo, e.lo);
            chk("busy_cycles", 32'(bcnt), 32'(e.len));
          end
          bcnt = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  // Drive one command for one accept edge; returns at accept edge + 1.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    logic [31:0] h, l;
    bus.start = 1'b1;
    bus.operation = op;
    bus.a = a;
    bus.b = b;
    if (track) begin
      model(op, a, b, h, l);
      if (op == F_MULT || op == F_MULTU || op == F_DIV || op == F_DIVU)
        sb.push_back('{hi: h, lo: l, len: 33});
      mhi = h;
      mlo = l;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.operation = 6'b100000;
    if (track && op == F_MTHI) chk("mthi_hi", bus.hi, a);
    if (track && op == F_MTLO) chk("mtlo_lo", bus.lo, a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) return;
      @(posedge clk);
      #1;
    end
    chk("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_mf();
    bus.operation = F_MFHI;
    #1 chk("mfhi", bus.mfResult, mhi);
    bus.operation = F_MFLO;
    #1 chk("mflo", bus.mfResult, mlo);
    bus.operation = 6'b100000;
    #1 chk("mf_other", bus.mfResult, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [5:0]  ops[6];
    logic [31:0] ra, rb;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.operation = F_MFHI;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_mf", bus.mfResult, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases.
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_idle();
    chk("multu_max_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_max_lo", bus.lo, 32'h00000001);
    issue(F_MULT, -32'sd3, 32'd7, 1); wait_idle();
    chk("mult_neg_lo", bus.lo, 32'hFFFFFFEB);
    issue(F_DIVU, 32'd100, 32'd7, 1); wait_idle();
    issue(F_DIV, -32'sd7, 32'd2, 1); wait_idle();
    chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1); wait_idle();
    chk("div_ovf_lo", bus.lo, 32'h80000000);
    issue(F_DIVU, 32'h1234, 32'h0, 1); wait_idle();
    chk("divu_zero_hi", bus.hi, 32'h1234);
    issue(F_DIV, 32'hFFFFFF00, 32'h0, 1); wait_idle();
    issue(F_MTHI, 32'hDEADBEEF, 32'h0, 1);
    check_mf();
    chk("mfhi_deadbeef", mhi, 32'hDEADBEEF);

    // A start while busy must be ignored.
    issue(F_MULT, 32'd12345, 32'hFFFFFFF0, 1);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.operation = F_MULT; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.operation = 6'b100000;
    wait_idle();
    check_mf();

    // Flush during iteration 10: busy seen for 10 cycles, HI/LO retained.
    sb.push_back('{hi: mhi, lo: mlo, len: 10});
    issue(F_MULT, 32'd99, 32'd77, 0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_hi", bus.hi, mhi);
    chk("flush_lo", bus.lo, mlo);

    // Flush in IDLE suppresses a same-cycle MTLO.
    @(posedge clk);
    #1 bus.flush = 1'b1;
    issue(F_MTLO, 32'h55AA55AA, 32'h0, 0);
    bus.flush = 1'b0;
    chk("flush_idle_lo", bus.lo, mlo);

    // Randomized commands against the reference.
    for (int n = 0; n < 40; n++) begin
      ra = pick();
      rb = pick();
      issue(ops[$urandom_range(0, 5)], ra, rb, 1);
      wait_idle();
      check_mf();
    end

    // Asynchronous reset mid-divide clears everything without an edge.
    issue(F_DIV, 32'd1000, 32'd3, 0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(bus.busy), 32'd0);
    chk("areset_hi", bus.hi, 32'd0);
    chk("areset_lo", bus.lo, 32'd0);
    mhi = '0;
    mlo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(F_DIVU, 32'd100, 32'd7, 1); wait_idle();
    chk("post_reset_lo", bus.lo, 32'd14);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
